// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults and pointer helpers for the convolution output path
package conv_pkg;
  localparam int OUTW_DEF = 24;
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: simple dual-port memory with registered, enable-held read and write-first forwarding
module fifo_mem_dp #(
  parameter int WIDTH = 24,
  parameter int SIZE  = 19,
  parameter int AW    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [SIZE];
  // storage is never reset; the read register holds whenever rd_en is low
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wdata;
    if (rd_en) rdata <= (wr_en && wr_addr == rd_addr) ? wdata : mem[rd_addr];
  end
endmodule

// File: rtl/fifo_out_prefetch.sv
// fifo_out_prefetch: output FIFO whose memory read register is the AXIS output stage
module fifo_out_prefetch
  import conv_pkg::*;
#(
  parameter int OUTW      = OUTW_DEF,
  parameter int DEPTH     = 19,
  parameter int AF_THRESH = DEPTH - 2,
  localparam int CW       = $clog2(DEPTH + 2),
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [OUTW-1:0] IN_AXIS_TDATA,
  input  logic            IN_AXIS_TVALID,
  output logic            IN_AXIS_TREADY,
  output logic [OUTW-1:0] OUT_AXIS_TDATA,
  output logic            OUT_AXIS_TVALID,
  input  logic            OUT_AXIS_TREADY,
  output logic [CW-1:0]   count,
  output logic            almost_full
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] mem_cnt, mem_nxt, cnt_nxt;
  logic          out_valid, out_nxt, live, wr_en, rd_en, pop;
  // live keeps READY low until the first edge after reset release
  assign IN_AXIS_TREADY  = live && (mem_cnt < CW'(DEPTH));
  assign OUT_AXIS_TVALID = out_valid;
  assign wr_en   = IN_AXIS_TVALID && IN_AXIS_TREADY && !flush;
  assign pop     = out_valid && OUT_AXIS_TREADY;
  assign rd_en   = (mem_cnt != '0) && (!out_valid || OUT_AXIS_TREADY) && !flush;
  assign mem_nxt = flush ? '0 : mem_cnt + CW'(wr_en) - CW'(rd_en);
  assign out_nxt = flush ? 1'b0 : rd_en ? 1'b1 : pop ? 1'b0 : out_valid;
  assign cnt_nxt = mem_nxt + CW'(out_nxt);
  fifo_mem_dp #(.WIDTH(OUTW), .SIZE(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wdata   (IN_AXIS_TDATA),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rdata   (OUT_AXIS_TDATA)
  );
  // pointers, occupancy and registered flags; flush clears everything at the edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      out_valid   <= 1'b0;
      count       <= '0;
      almost_full <= 1'b0;
      live        <= 1'b0;
    end else begin
      live        <= 1'b1;
      wr_ptr      <= flush ? '0 : wr_en ? AW'(ptr_inc(32'(wr_ptr), DEPTH)) : wr_ptr;
      rd_ptr      <= flush ? '0 : rd_en ? AW'(ptr_inc(32'(rd_ptr), DEPTH)) : rd_ptr;
      mem_cnt     <= mem_nxt;
      out_valid   <= out_nxt;
      count       <= cnt_nxt;
      almost_full <= cnt_nxt >= CW'(AF_THRESH);
    end
  end
endmodule

// File: tb/tb_fifo_out_prefetch.sv
// tb_fifo_out_prefetch: directed self-checking bench for fifo_out_prefetch
module tb_fifo_out_prefetch;
  localparam int OUTW  = 24;
  localparam int DEPTH = 19;
  localparam int CW    = $clog2(DEPTH + 2);
  logic            clk = 1'b0;
  logic            reset, flush;
  logic [OUTW-1:0] in_tdata, out_tdata;
  logic            in_tvalid, in_tready, out_tvalid, out_tready, almost_full;
  logic [CW-1:0]   count;
  int              tests = 0, fails = 0, cnt_m = 0, pops = 0, p0;
  logic [OUTW-1:0] q[$];

  fifo_out_prefetch #(.OUTW(OUTW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .IN_AXIS_TDATA   (in_tdata),
    .IN_AXIS_TVALID  (in_tvalid),
    .IN_AXIS_TREADY  (in_tready),
    .OUT_AXIS_TDATA  (out_tdata),
    .OUT_AXIS_TVALID (out_tvalid),
    .OUT_AXIS_TREADY (out_tready),
    .count           (count),
    .almost_full     (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock with scoreboard, count model and AXIS stability checks
  task automatic tick(input string tag);
    logic acc, pp, stall;
    logic [OUTW-1:0] id, od;
    acc   = in_tvalid && in_tready;
    pp    = out_tvalid && out_tready;
    stall = out_tvalid && !out_tready;
    id    = in_tdata;
    od    = out_tdata;
    @(posedge clk);
    #1;
    if (acc) q.push_back(id);
    if (pp) begin
      pops++;
      chk({tag, " pop_nonempty"}, 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) chk({tag, " order"}, 32'(od), 32'(q.pop_front()));
    end
    cnt_m += int'(acc) - int'(pp);
    chk({tag, " count"}, 32'(count), cnt_m);
    if (stall) begin
      chk({tag, " stall_valid"}, 32'(out_tvalid), 32'd1);
      chk({tag, " stall_data"}, 32'(out_tdata), 32'(od));
    end
  endtask

  initial begin
    // T1 reset with random inputs
    reset = 1'b0;
    flush = 1'b0;
    in_tvalid = 1'b1;
    in_tdata = 24'($urandom);
    out_tready = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    chk("T1 ready", 32'(in_tready), 32'd0);
    chk("T1 valid", 32'(out_tvalid), 32'd0);
    chk("T1 count", 32'(count), 32'd0);
    chk("T1 af", 32'(almost_full), 32'd0);
    reset = 1'b1;
    in_tvalid = 1'b0;
    out_tready = 1'b0;
    #1;
    chk("T1 ready_pre_edge", 32'(in_tready), 32'd0);
    @(posedge clk);
    #1;
    chk("T1 ready_first_edge", 32'(in_tready), 32'd1);
    // T2 fill to full with sink stalled
    for (int v = 0; v < 26; v++) begin
      in_tdata = 24'(v);
      in_tvalid = 1'b1;
      chk("T2 ready", 32'(in_tready), 32'(v < 20));
      tick("T2");
      chk("T2 count_hand", 32'(count), (v + 1 > 20) ? 20 : v + 1);
      chk("T2 af", 32'(almost_full), 32'(((v + 1 > 20) ? 20 : v + 1) >= 17));
    end
    in_tvalid = 1'b0;
    chk("T2 head_valid", 32'(out_tvalid), 32'd1);
    chk("T2 head_data", 32'(out_tdata), 32'd0);
    out_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("T2 drain_valid", 32'(out_tvalid), 32'd1);
      chk("T2 drain_data", 32'(out_tdata), i);
      tick("T2d");
    end
    chk("T2 empty_valid", 32'(out_tvalid), 32'd0);
    chk("T2 empty_count", 32'(count), 32'd0);
    // T3 latency then full-rate burst
    in_tdata = 24'hA5;
    in_tvalid = 1'b1;
    tick("T3");
    in_tvalid = 1'b0;
    chk("T3 valid_c1", 32'(out_tvalid), 32'd0);
    tick("T3");
    chk("T3 valid_c2", 32'(out_tvalid), 32'd1);
    chk("T3 data_c2", 32'(out_tdata), 32'hA5);
    tick("T3");
    p0 = pops;
    for (int i = 1; i <= 100; i++) begin
      in_tdata = 24'(i);
      in_tvalid = 1'b1;
      tick("T3b");
    end
    in_tvalid = 1'b0;
    tick("T3b");
    tick("T3b");
    chk("T3 burst_pops", pops - p0, 32'd100);
    chk("T3 burst_count", 32'(count), 32'd0);
    // T4 random traffic across many pointer wraps
    for (int i = 0; i < 200; i++) begin
      in_tvalid = ($urandom_range(0, 3) != 0);
      in_tdata = 24'($urandom);
      out_tready = 1'($urandom_range(0, 1));
      tick("T4");
    end
    in_tvalid = 1'b0;
    out_tready = 1'b1;
    repeat (25) tick("T4d");
    chk("T4 sb_empty", 32'(q.size()), 32'd0);
    chk("T4 count_zero", 32'(count), 32'd0);
    // T5 flush with concurrent handshakes
    out_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_tdata = 24'h500 + 24'(i);
      in_tvalid = 1'b1;
      tick("T5");
    end
    chk("T5 queued", 32'(count), 32'd10);
    flush = 1'b1;
    in_tdata = 24'hBEEF;
    out_tready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_tvalid = 1'b0;
    chk("T5 count", 32'(count), 32'd0);
    chk("T5 valid", 32'(out_tvalid), 32'd0);
    chk("T5 af", 32'(almost_full), 32'd0);
    q.delete();
    cnt_m = 0;
    p0 = pops;
    repeat (3) tick("T5p");
    chk("T5 no_output", pops - p0, 32'd0);
    in_tdata = 24'h77;
    in_tvalid = 1'b1;
    tick("T5n");
    in_tvalid = 1'b0;
    repeat (3) tick("T5n");
    chk("T5 new_word_out", pops - p0, 32'd1);
    // T6 asynchronous reset mid-stream
    out_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_tdata = 24'h600 + 24'(i);
      in_tvalid = 1'b1;
      tick("T6");
    end
    in_tvalid = 1'b0;
    chk("T6 count7", 32'(count), 32'd7);
    #2 reset = 1'b0;
    #1;
    chk("T6 valid_async", 32'(out_tvalid), 32'd0);
    chk("T6 count_async", 32'(count), 32'd0);
    chk("T6 ready_async", 32'(in_tready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    cnt_m = 0;
    tick("T6r");
    chk("T6 ready_after", 32'(in_tready), 32'd1);
    out_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_tdata = 24'h700 + 24'(i);
      in_tvalid = 1'b1;
      tick("T6c");
    end
    in_tvalid = 1'b0;
    repeat (4) tick("T6c");
    chk("T6 sb_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
